cache_arbiter_8_16: RTL and testbench
=====================================

CACHE_ARBITER_8_16 -- requirements
Module: cache_arbiter_8_16

Interface
REQ-001 Parameter: DEPTH, default 8, number of cache words (fixed at 8; address width 3).
REQ-002 Parameter: WIDTH, default 16, bits per cache word.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: wr0_valid  input  1  requester 0 write request.
REQ-006 Port: wr0_addr  input  3  requester 0 target word.
REQ-007 Port: wr0_data  input  16  requester 0 write data.
REQ-008 Port: wr0_ready  output  1  requester 0 accepted this cycle.
REQ-009 Port: wr1_valid / wr1_addr / wr1_data / wr1_ready  same widths and meaning for requester 1.
REQ-010 Port: clear_req  input  1  request zeroing sweep of all words.
REQ-011 Port: busy  output  1  high while the clear sweep runs.
REQ-012 Port: clear_done  output  1  one-cycle pulse on the last sweep cycle.
REQ-013 Port: rd_addr  input  3  read select.
REQ-014 Port: rd_data  output  16  combinational contents of word rd_addr.
REQ-015 Port: mem_state  output  8x16  combinational view of all eight words.

Function
REQ-016 A write transfer occurs on a rising edge where wrN_valid and wrN_ready are both high; the addressed word holds the new data from the following cycle onward (latency 1).
REQ-017 wrN_ready is combinational, depends on valid, state and priority only, and is never high for both requesters in the same cycle.
REQ-018 FSM states: IDLE, CLEAR; reset state IDLE.
REQ-019 IDLE, clear_req low: if exactly one requester is valid, that requester gets ready; if both are valid, the requester selected by the priority pointer gets ready.
REQ-020 Priority pointer resets to 0 (requester 0 wins a tie) and, after each accepted transfer, points to the requester not just served; it does not change in cycles without a transfer.
REQ-021 IDLE, clear_req high: transition to CLEAR, sweep index = 0, no ready asserted that cycle (clear beats writes).
REQ-022 CLEAR: each cycle writes zero to word sweep index, then increments it; busy high; both readies low; clear_req ignored.
REQ-023 CLEAR with sweep index 7: clear_done high for that cycle, word 7 zeroed, return to IDLE; sweep lasts exactly 8 cycles.
REQ-024 Words not addressed by a transfer or sweep hold their value indefinitely.
REQ-025 rd_data and mem_state reflect the registered contents; a same-cycle write to rd_addr is not bypassed.

Reset
REQ-026 rst high at a rising edge forces: all 8 words = 0, FSM = IDLE, sweep index = 0, priority pointer = 0, busy = 0, clear_done = 0, both readies = 0 during the rst cycle.
REQ-027 rst during CLEAR aborts the sweep; IDLE operation resumes in the cycle after rst deasserts.

Structure
REQ-028 Package cache_arb_pkg holds DEPTH/WIDTH/address-width constants and the FSM state enum.
REQ-029 Storage is one sub-module, cache_regfile_8_16 (single write port: we, waddr, wdata; combinational full-state output); the arbiter drives its write port from the granted requester or the sweep.

Verification
REQ-030 After reset, wr0 addr 3 data 0x00AA alone -> wr0_ready=1 same cycle, mem_state[3]=0x00AA next cycle, all other words 0.
REQ-031 Both valid every cycle (wr0 addr 1 data 0x1111, wr1 addr 2 data 0x2222) for 4 cycles -> grants alternate 0,1,0,1; never both ready.
REQ-032 Both valid to addr 5 (wr0 0x0005, wr1 0x0050), pointer 0 -> word 5 = 0x0005 then 0x0050 after second cycle.
REQ-033 Fill all words with 0xFFFF, pulse clear_req with both writers valid -> no ready for 9 cycles (request cycle + 8 sweep), busy high 8 cycles, clear_done on 8th, all words 0.
REQ-034 rst asserted on 3rd sweep cycle -> busy=0 next cycle, all words 0, pointer 0, writes accepted after rst deasserts.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared constants and FSM encoding for the two-requester cache word arbiter.
package cache_arb_pkg;
  localparam int CA_DEPTH = 8;
  localparam int CA_WIDTH = 16;
  localparam int CA_AW    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;
endpackage

// File: rtl/cache_regfile_8_16.sv
// Eight-word register file with a single write port and a combinational full-state view.
module cache_regfile_8_16
  import cache_arb_pkg::*;
#(
  parameter int DEPTH = CA_DEPTH,
  parameter int WIDTH = CA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [CA_AW-1:0]             waddr,
  input  logic [WIDTH-1:0]             wdata,
  output logic [DEPTH-1:0][WIDTH-1:0]  mem_state
);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign mem_state = r_mem;

endmodule

// File: rtl/cache_arbiter_8_16.sv
// Two-requester write arbiter with round-robin tie-break and a zeroing sweep over all words.
module cache_arbiter_8_16
  import cache_arb_pkg::*;
#(
  parameter int DEPTH = CA_DEPTH,
  parameter int WIDTH = CA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr0_valid,
  input  logic [CA_AW-1:0]             wr0_addr,
  input  logic [WIDTH-1:0]             wr0_data,
  output logic                         wr0_ready,
  input  logic                         wr1_valid,
  input  logic [CA_AW-1:0]             wr1_addr,
  input  logic [WIDTH-1:0]             wr1_data,
  output logic                         wr1_ready,
  input  logic                         clear_req,
  output logic                         busy,
  output logic                         clear_done,
  input  logic [CA_AW-1:0]             rd_addr,
  output logic [WIDTH-1:0]             rd_data,
  output logic [DEPTH-1:0][WIDTH-1:0]  mem_state
);

  localparam logic [CA_AW-1:0] LAST_IDX = CA_AW'(DEPTH - 1);

  arb_state_e       r_state, w_state_nxt;
  logic [CA_AW-1:0] r_sweep, w_sweep_nxt;
  logic             r_prio, w_prio_nxt;

  logic             w_rdy0, w_rdy1, w_busy, w_done;
  logic             w_we;
  logic [CA_AW-1:0] w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [DEPTH-1:0][WIDTH-1:0] w_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sweep <= '0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sweep <= w_sweep_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep;
    w_prio_nxt  = r_prio;
    w_rdy0      = 1'b0;
    w_rdy1      = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_we        = 1'b0;
    w_waddr     = '0;
    w_wdata     = '0;

    case (r_state)
      IDLE: begin
        w_sweep_nxt = '0;
        // A pending clear wins over both writers for this cycle.
        if (clear_req) begin
          w_state_nxt = CLEAR;
        end else begin
          w_rdy0 = wr0_valid && (!wr1_valid || !r_prio);
          w_rdy1 = wr1_valid && !w_rdy0;
          if (w_rdy0) begin
            w_we       = 1'b1;
            w_waddr    = wr0_addr;
            w_wdata    = wr0_data;
            w_prio_nxt = 1'b1;
          end else if (w_rdy1) begin
            w_we       = 1'b1;
            w_waddr    = wr1_addr;
            w_wdata    = wr1_data;
            w_prio_nxt = 1'b0;
          end
        end
      end
      CLEAR: begin
        w_busy      = 1'b1;
        w_we        = 1'b1;
        w_waddr     = r_sweep;
        w_wdata     = '0;
        w_sweep_nxt = r_sweep + 1'b1;
        if (r_sweep == LAST_IDX) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Reset cycle presents a quiet interface regardless of the current state.
    if (rst) begin
      w_rdy0 = 1'b0;
      w_rdy1 = 1'b0;
      w_busy = 1'b0;
      w_done = 1'b0;
      w_we   = 1'b0;
    end
  end

  cache_regfile_8_16 #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (w_we),
    .waddr     (w_waddr),
    .wdata     (w_wdata),
    .mem_state (w_mem)
  );

  assign wr0_ready  = w_rdy0;
  assign wr1_ready  = w_rdy1;
  assign busy       = w_busy;
  assign clear_done = w_done;
  assign mem_state  = w_mem;
  assign rd_data    = w_mem[rd_addr];

endmodule

// File: tb/tb_cache_arbiter_8_16.sv
// Self-checking bench for cache_arbiter_8_16: directed scenarios plus randomized traffic vs a queue-based model.
module tb_cache_arbiter_8_16;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr0_valid, wr1_valid, clear_req;
  logic [2:0]       wr0_addr, wr1_addr, rd_addr;
  logic [15:0]      wr0_data, wr1_data;
  logic             wr0_ready, wr1_ready, busy, clear_done;
  logic [15:0]      rd_data;
  logic [7:0][15:0] mem_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory image, tie-break owner, and the addresses a sweep still has to zero.
  logic [15:0] m_mem [8];
  bit          m_prio;
  int          m_q [$];

  cache_arbiter_8_16 dut (
    .clk        (clk),
    .rst        (rst),
    .wr0_valid  (wr0_valid),
    .wr0_addr   (wr0_addr),
    .wr0_data   (wr0_data),
    .wr0_ready  (wr0_ready),
    .wr1_valid  (wr1_valid),
    .wr1_addr   (wr1_addr),
    .wr1_data   (wr1_data),
    .wr1_ready  (wr1_ready),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .mem_state  (mem_state)
  );

  always #5 clk = ~clk;

  task automatic expected(output bit e0, output bit e1, output bit eb, output bit ed);
    e0 = 0; e1 = 0; eb = 0; ed = 0;
    if (rst === 1'b1) return;
    eb = (m_q.size() > 0);
    ed = (m_q.size() == 1);
    if (eb || clear_req === 1'b1) return;
    e0 = (wr0_valid === 1'b1) && (wr1_valid !== 1'b1 || m_prio == 0);
    e1 = (wr1_valid === 1'b1) && (wr0_valid !== 1'b1 || m_prio == 1);
  endtask

  task automatic commit();
    bit e0, e1, eb, ed;
    expected(e0, e1, eb, ed);
    if (rst === 1'b1) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 16'h0;
      m_prio = 0;
      m_q.delete();
    end else if (eb) begin
      m_mem[m_q.pop_front()] = 16'h0;
    end else if (clear_req === 1'b1) begin
      for (int i = 0; i < 8; i++) m_q.push_back(i);
    end else if (e0) begin
      m_mem[wr0_addr] = wr0_data;
      m_prio = 1;
    end else if (e1) begin
      m_mem[wr1_addr] = wr1_data;
      m_prio = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic idle_inputs();
    wr0_valid = 0; wr1_valid = 0; clear_req = 0;
    wr0_addr = 0; wr1_addr = 0; wr0_data = 0; wr1_data = 0; rd_addr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; wr0_valid = 1; wr1_valid = 1; clear_req = 1;
    @(negedge clk);
    n_checks++;
    if ({wr0_ready, wr1_ready, busy, clear_done} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_outputs: got rdy0/rdy1/busy/done=%b required 0000", {wr0_ready, wr1_ready, busy, clear_done});
    end
    tick();
    tick();
    rst = 0; wr0_valid = 0; wr1_valid = 0; clear_req = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (mem_state[i] !== 16'h0) begin
        n_errors++;
        $display("FAIL reset_word[%0d]: got %h required 0000", i, mem_state[i]);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    wr0_valid = 1; wr0_addr = 3'd3; wr0_data = 16'h00AA;
    @(negedge clk);
    n_checks++;
    if (wr0_ready !== 1'b1 || wr1_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL single_ready: got rdy0=%b rdy1=%b required 1 0", wr0_ready, wr1_ready);
    end
    tick();
    wr0_valid = 0; rd_addr = 3'd3;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (mem_state[i] !== ((i == 3) ? 16'h00AA : 16'h0000)) begin
        n_errors++;
        $display("FAIL single_word[%0d]: got %h required %h", i, mem_state[i], (i == 3) ? 16'h00AA : 16'h0000);
      end
    end
    n_checks++;
    if (rd_data !== 16'h00AA) begin
      n_errors++;
      $display("FAIL single_rd_data: got %h required 00aa", rd_data);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    wr0_valid = 1; wr0_addr = 3'd1; wr0_data = 16'h1111;
    wr1_valid = 1; wr1_addr = 3'd2; wr1_data = 16'h2222;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (wr0_ready !== (c % 2 == 0) || wr1_ready !== (c % 2 == 1)) begin
        n_errors++;
        $display("FAIL alternate_grant[%0d]: got rdy0=%b rdy1=%b required %0d %0d", c, wr0_ready, wr1_ready, c % 2 == 0, c % 2 == 1);
      end
      tick();
    end
    wr0_valid = 0; wr1_valid = 0;
    @(negedge clk);
    n_checks++;
    if (mem_state[1] !== 16'h1111 || mem_state[2] !== 16'h2222) begin
      n_errors++;
      $display("FAIL alternate_words: got w1=%h w2=%h required 1111 2222", mem_state[1], mem_state[2]);
    end
  endtask

  task automatic test_same_addr();
    do_reset();
    wr0_valid = 1; wr0_addr = 3'd5; wr0_data = 16'h0005;
    wr1_valid = 1; wr1_addr = 3'd5; wr1_data = 16'h0050;
    tick();
    @(negedge clk);
    n_checks++;
    if (mem_state[5] !== 16'h0005 || wr1_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL same_addr_first: got w5=%h rdy1=%b required 0005 1", mem_state[5], wr1_ready);
    end
    tick();
    wr0_valid = 0; wr1_valid = 0;
    @(negedge clk);
    n_checks++;
    if (mem_state[5] !== 16'h0050) begin
      n_errors++;
      $display("FAIL same_addr_second: got %h required 0050", mem_state[5]);
    end
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    int done_at  = -1;
    int done_cnt = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr0_valid = 1; wr0_addr = 3'(i); wr0_data = 16'hFFFF;
      tick();
    end
    wr1_valid = 1; wr1_addr = 3'd4; wr1_data = 16'h1234; clear_req = 1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      n_checks++;
      if (wr0_ready !== 1'b0 || wr1_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL clear_no_ready[%0d]: got rdy0=%b rdy1=%b required 0 0", c, wr0_ready, wr1_ready);
      end
      if (busy === 1'b1) busy_cnt++;
      if (clear_done === 1'b1) begin done_at = c; done_cnt++; end
      tick();
      clear_req = 0;
    end
    @(negedge clk);
    n_checks++;
    if (busy_cnt != 8 || done_cnt != 1 || done_at != 8) begin
      n_errors++;
      $display("FAIL clear_timing: got busy_cycles=%0d done_pulses=%0d done_at=%0d required 8 1 8", busy_cnt, done_cnt, done_at);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (mem_state[i] !== 16'h0) begin
        n_errors++;
        $display("FAIL clear_word[%0d]: got %h required 0000", i, mem_state[i]);
      end
    end
    n_checks++;
    if (busy !== 1'b0 || (wr0_ready ^ wr1_ready) !== 1'b1) begin
      n_errors++;
      $display("FAIL clear_resume: got busy=%b rdy0=%b rdy1=%b required busy 0 and one ready", busy, wr0_ready, wr1_ready);
    end
    wr0_valid = 0; wr1_valid = 0;
  endtask

  task automatic test_clear_reset();
    do_reset();
    wr0_valid = 1; wr0_addr = 3'd7; wr0_data = 16'hABCD;
    tick();
    wr0_valid = 0; clear_req = 1;
    tick();
    clear_req = 0;
    tick();
    tick();
    rst = 1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_rst_busy_in_rst: got %b required 0", busy);
    end
    tick();
    rst = 0;
    wr0_valid = 1; wr0_addr = 3'd6; wr0_data = 16'h1234;
    wr1_valid = 1; wr1_addr = 3'd6; wr1_data = 16'h5678;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wr0_ready !== 1'b1 || wr1_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_rst_resume: got busy=%b rdy0=%b rdy1=%b required 0 1 0", busy, wr0_ready, wr1_ready);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (mem_state[i] !== 16'h0) begin
        n_errors++;
        $display("FAIL clear_rst_word[%0d]: got %h required 0000", i, mem_state[i]);
      end
    end
    tick();
    wr0_valid = 0; wr1_valid = 0;
    @(negedge clk);
    n_checks++;
    if (mem_state[6] !== 16'h1234) begin
      n_errors++;
      $display("FAIL clear_rst_write: got %h required 1234", mem_state[6]);
    end
  endtask

  task automatic test_random();
    bit e0, e1, eb, ed;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(63) == 0);
      clear_req = ($urandom_range(19) == 0);
      wr0_valid = ($urandom_range(3) != 0);
      wr1_valid = ($urandom_range(3) != 0);
      wr0_addr  = 3'($urandom_range(7));
      wr1_addr  = 3'($urandom_range(7));
      wr0_data  = 16'($urandom);
      wr1_data  = 16'($urandom);
      rd_addr   = 3'($urandom_range(7));
      @(negedge clk);
      expected(e0, e1, eb, ed);
      n_checks++;
      if (wr0_ready !== e0 || wr1_ready !== e1 || busy !== eb || clear_done !== ed) begin
        n_errors++;
        $display("FAIL rand_ctrl[%0d]: got rdy0/rdy1/busy/done=%b%b%b%b required %b%b%b%b", c, wr0_ready, wr1_ready, busy, clear_done, e0, e1, eb, ed);
      end
      n_checks++;
      if (rd_data !== m_mem[rd_addr]) begin
        n_errors++;
        $display("FAIL rand_rd_data[%0d]: got %h required %h", c, rd_data, m_mem[rd_addr]);
      end
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (mem_state[i] !== m_mem[i]) begin
          n_errors++;
          $display("FAIL rand_word[%0d][%0d]: got %h required %h", c, i, mem_state[i], m_mem[i]);
        end
      end
      tick();
    end
    idle_inputs();
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_mem[i] = 16'h0;
    m_prio = 0;
    idle_inputs();
    rst = 1;
    test_reset();
    test_single_write();
    test_alternate();
    test_same_addr();
    test_clear();
    test_clear_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
